// File: rtl/wb_sched.sv
// wb_sched: arbitrates the single register-file write port between the integer and load-store pipes,
// lsp-first with an ip anti-starvation override, one registered stage into the register file.
module wb_sched #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       ip_wb_dst,
  input  logic [63:0]      ip_wb_result,
  input  logic             ip_wb_wb_en,
  input  logic             ip_wb_valid,
  output logic             ip_wb_ready,
  input  logic [4:0]       lsp_wb_dst,
  input  logic [63:0]      lsp_wb_result,
  input  logic             lsp_wb_wb_en,
  input  logic             lsp_wb_valid,
  output logic             lsp_wb_ready,
  output logic             rf_wen,
  output logic [4:0]       rf_wdst,
  output logic [63:0]      rf_wdata,
  output logic             sb_clr_en,
  output logic [4:0]       sb_clr_dst,
  output logic             ip_retire,
  output logic             lsp_retire,
  output logic [CNT_W-1:0] starve_cnt
);
  logic             w_ip_wreq, w_ip_nowb, w_lsp_wreq, w_lsp_nowb;
  logic             w_force_ip, w_grant_ip, w_grant_lsp, w_ip_acc, w_lsp_acc;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             r_wen, r_ip_retire, r_lsp_retire;
  logic [4:0]       r_wdst;
  logic [63:0]      r_wdata;
  logic [CNT_W-1:0] r_cnt;

  assign w_ip_wreq   = ip_wb_valid && ip_wb_wb_en && (ip_wb_dst != 5'd0);
  assign w_ip_nowb   = ip_wb_valid && !w_ip_wreq;
  assign w_lsp_wreq  = lsp_wb_valid && lsp_wb_wb_en && (lsp_wb_dst != 5'd0);
  assign w_lsp_nowb  = lsp_wb_valid && !w_lsp_wreq;
  assign w_force_ip  = r_cnt >= CNT_W'(STARVE_LIMIT);
  assign w_grant_ip  = w_ip_wreq && (!w_lsp_wreq || w_force_ip);
  assign w_grant_lsp = w_lsp_wreq && !w_grant_ip;
  // Nothing is accepted while reset is held, so no retire pulse can be lost.
  assign w_ip_acc    = rst_n && (w_ip_nowb || w_grant_ip);
  assign w_lsp_acc   = rst_n && (w_lsp_nowb || w_grant_lsp);

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_ip_wreq && w_grant_lsp)
      w_cnt_nxt = (r_cnt == {CNT_W{1'b1}}) ? r_cnt : r_cnt + 1'b1;
    else if (w_grant_ip || !w_ip_wreq)
      w_cnt_nxt = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wen        <= 1'b0;
      r_wdst       <= '0;
      r_wdata      <= '0;
      r_ip_retire  <= 1'b0;
      r_lsp_retire <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_wen        <= w_grant_ip || w_grant_lsp;
      r_ip_retire  <= w_ip_acc;
      r_lsp_retire <= w_lsp_acc;
      r_cnt        <= w_cnt_nxt;
      if (w_grant_ip || w_grant_lsp) begin
        r_wdst  <= w_grant_ip ? ip_wb_dst : lsp_wb_dst;
        r_wdata <= w_grant_ip ? ip_wb_result : lsp_wb_result;
      end
    end
  end

  assign ip_wb_ready  = w_ip_acc;
  assign lsp_wb_ready = w_lsp_acc;
  assign rf_wen       = r_wen;
  assign rf_wdst      = r_wdst;
  assign rf_wdata     = r_wdata;
  assign sb_clr_en    = r_wen;
  assign sb_clr_dst   = r_wdst;
  assign ip_retire    = r_ip_retire;
  assign lsp_retire   = r_lsp_retire;
  assign starve_cnt   = r_cnt;
endmodule

// File: tb/tb_wb_sched.sv
// tb_wb_sched: directed per-feature checks of wb_sched with hand-computed expectations.
module tb_wb_sched;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [4:0]  ip_wb_dst = '0, lsp_wb_dst = '0;
  logic [63:0] ip_wb_result = '0, lsp_wb_result = '0;
  logic        ip_wb_wb_en = 1'b0, ip_wb_valid = 1'b0, lsp_wb_wb_en = 1'b0, lsp_wb_valid = 1'b0;
  logic        ip_wb_ready, lsp_wb_ready, rf_wen, sb_clr_en, ip_retire, lsp_retire;
  logic [4:0]  rf_wdst, sb_clr_dst;
  logic [63:0] rf_wdata;
  logic [2:0]  starve_cnt;
  int          pass_cnt = 0, total_cnt = 0;

  wb_sched #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .ip_wb_dst(ip_wb_dst), .ip_wb_result(ip_wb_result), .ip_wb_wb_en(ip_wb_wb_en),
    .ip_wb_valid(ip_wb_valid), .ip_wb_ready(ip_wb_ready),
    .lsp_wb_dst(lsp_wb_dst), .lsp_wb_result(lsp_wb_result), .lsp_wb_wb_en(lsp_wb_wb_en),
    .lsp_wb_valid(lsp_wb_valid), .lsp_wb_ready(lsp_wb_ready),
    .rf_wen(rf_wen), .rf_wdst(rf_wdst), .rf_wdata(rf_wdata),
    .sb_clr_en(sb_clr_en), .sb_clr_dst(sb_clr_dst),
    .ip_retire(ip_retire), .lsp_retire(lsp_retire), .starve_cnt(starve_cnt)
  );

  always #5 clk = ~clk;

  task automatic drive_ip(input logic v, input logic en, input logic [4:0] d, input logic [63:0] r);
    ip_wb_valid = v; ip_wb_wb_en = en; ip_wb_dst = d; ip_wb_result = r;
  endtask

  task automatic drive_lsp(input logic v, input logic en, input logic [4:0] d, input logic [63:0] r);
    lsp_wb_valid = v; lsp_wb_wb_en = en; lsp_wb_dst = d; lsp_wb_result = r;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    drive_ip(1'b1, 1'b0, 5'd1, 64'h0);
    drive_lsp(1'b1, 1'b1, 5'd2, 64'h55);
    repeat (2) @(posedge clk);
    #1;
    total_cnt++; if (rf_wen !== 1'b0) $display("FAIL reset_rf_wen got %0b want 0", rf_wen); else pass_cnt++;
    total_cnt++; if (rf_wdst !== 5'd0) $display("FAIL reset_rf_wdst got %0d want 0", rf_wdst); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 64'd0) $display("FAIL reset_rf_wdata got %0h want 0", rf_wdata); else pass_cnt++;
    total_cnt++; if (sb_clr_en !== 1'b0 || sb_clr_dst !== 5'd0) $display("FAIL reset_sb got %0b/%0d want 0/0", sb_clr_en, sb_clr_dst); else pass_cnt++;
    total_cnt++; if (ip_retire !== 1'b0 || lsp_retire !== 1'b0) $display("FAIL reset_retire got %0b%0b want 00", ip_retire, lsp_retire); else pass_cnt++;
    total_cnt++; if (starve_cnt !== 3'd0) $display("FAIL reset_starve got %0d want 0", starve_cnt); else pass_cnt++;
    total_cnt++; if (ip_wb_ready !== 1'b0 || lsp_wb_ready !== 1'b0) $display("FAIL reset_ready got %0b%0b want 00", ip_wb_ready, lsp_wb_ready); else pass_cnt++;
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    drive_lsp(1'b0, 1'b0, 5'd0, 64'h0);
    rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_single_ip();
    drive_ip(1'b1, 1'b1, 5'd5, 64'h1234);
    #1;
    total_cnt++; if (ip_wb_ready !== 1'b1) $display("FAIL single_ip_ready got %0b want 1", ip_wb_ready); else pass_cnt++;
    total_cnt++; if (lsp_wb_ready !== 1'b0) $display("FAIL single_lsp_ready got %0b want 0", lsp_wb_ready); else pass_cnt++;
    next_cycle();
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    total_cnt++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd5) $display("FAIL single_wr got wen=%0b dst=%0d want 1/5", rf_wen, rf_wdst); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 64'h1234) $display("FAIL single_data got %0h want 1234", rf_wdata); else pass_cnt++;
    total_cnt++; if (sb_clr_en !== 1'b1 || sb_clr_dst !== 5'd5) $display("FAIL single_sb got %0b/%0d want 1/5", sb_clr_en, sb_clr_dst); else pass_cnt++;
    total_cnt++; if (ip_retire !== 1'b1 || lsp_retire !== 1'b0) $display("FAIL single_retire got %0b%0b want 10", ip_retire, lsp_retire); else pass_cnt++;
    next_cycle();
    total_cnt++; if (rf_wen !== 1'b0 || sb_clr_en !== 1'b0 || ip_retire !== 1'b0) $display("FAIL single_idle got %0b%0b%0b want 000", rf_wen, sb_clr_en, ip_retire); else pass_cnt++;
    total_cnt++; if (rf_wdst !== 5'd5 || rf_wdata !== 64'h1234) $display("FAIL single_hold got %0d/%0h want 5/1234", rf_wdst, rf_wdata); else pass_cnt++;
  endtask

  task automatic test_simultaneous();
    drive_ip(1'b1, 1'b1, 5'd3, 64'h33);
    drive_lsp(1'b1, 1'b1, 5'd4, 64'h44);
    #1;
    total_cnt++; if (lsp_wb_ready !== 1'b1 || ip_wb_ready !== 1'b0) $display("FAIL simul_c0_ready got lsp=%0b ip=%0b want 1/0", lsp_wb_ready, ip_wb_ready); else pass_cnt++;
    next_cycle();
    drive_lsp(1'b0, 1'b0, 5'd0, 64'h0);
    total_cnt++; if (starve_cnt !== 3'd1) $display("FAIL simul_starve got %0d want 1", starve_cnt); else pass_cnt++;
    total_cnt++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd4 || rf_wdata !== 64'h44) $display("FAIL simul_c1_wr got %0b/%0d/%0h want 1/4/44", rf_wen, rf_wdst, rf_wdata); else pass_cnt++;
    total_cnt++; if (lsp_retire !== 1'b1 || ip_retire !== 1'b0) $display("FAIL simul_c1_retire got lsp=%0b ip=%0b want 1/0", lsp_retire, ip_retire); else pass_cnt++;
    #1;
    total_cnt++; if (ip_wb_ready !== 1'b1) $display("FAIL simul_c1_ip_ready got %0b want 1", ip_wb_ready); else pass_cnt++;
    next_cycle();
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    total_cnt++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd3 || rf_wdata !== 64'h33) $display("FAIL simul_c2_wr got %0b/%0d/%0h want 1/3/33", rf_wen, rf_wdst, rf_wdata); else pass_cnt++;
    total_cnt++; if (ip_retire !== 1'b1 || lsp_retire !== 1'b0 || starve_cnt !== 3'd0) $display("FAIL simul_c2_state got ip=%0b lsp=%0b cnt=%0d want 1/0/0", ip_retire, lsp_retire, starve_cnt); else pass_cnt++;
  endtask

  task automatic test_starvation();
    int cnt = 0;
    logic exp_ip;
    drive_ip(1'b1, 1'b1, 5'd10, 64'hA0);
    drive_lsp(1'b1, 1'b1, 5'd11, 64'hB0);
    for (int c = 0; c < 10; c++) begin
      exp_ip = (cnt >= 4);
      #1;
      total_cnt++; if (ip_wb_ready !== exp_ip || lsp_wb_ready !== !exp_ip) $display("FAIL starve_ready[%0d] got ip=%0b lsp=%0b want ip=%0b", c, ip_wb_ready, lsp_wb_ready, exp_ip); else pass_cnt++;
      next_cycle();
      cnt = exp_ip ? 0 : cnt + 1;
      total_cnt++; if (starve_cnt !== 3'(cnt)) $display("FAIL starve_cnt[%0d] got %0d want %0d", c, starve_cnt, cnt); else pass_cnt++;
      total_cnt++; if (rf_wdst !== (exp_ip ? 5'd10 : 5'd11)) $display("FAIL starve_wdst[%0d] got %0d want %0d", c, rf_wdst, exp_ip ? 10 : 11); else pass_cnt++;
    end
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    drive_lsp(1'b0, 1'b0, 5'd0, 64'h0);
    next_cycle();
  endtask

  task automatic test_nowb();
    drive_ip(1'b1, 1'b0, 5'd9, 64'h99);
    drive_lsp(1'b1, 1'b1, 5'd7, 64'h77);
    #1;
    total_cnt++; if (ip_wb_ready !== 1'b1 || lsp_wb_ready !== 1'b1) $display("FAIL nowb_ready got ip=%0b lsp=%0b want 1/1", ip_wb_ready, lsp_wb_ready); else pass_cnt++;
    next_cycle();
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    drive_lsp(1'b0, 1'b0, 5'd0, 64'h0);
    total_cnt++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd7 || rf_wdata !== 64'h77) $display("FAIL nowb_wr got %0b/%0d/%0h want 1/7/77", rf_wen, rf_wdst, rf_wdata); else pass_cnt++;
    total_cnt++; if (ip_retire !== 1'b1 || lsp_retire !== 1'b1) $display("FAIL nowb_retire got ip=%0b lsp=%0b want 1/1", ip_retire, lsp_retire); else pass_cnt++;
  endtask

  task automatic test_x0();
    drive_ip(1'b1, 1'b1, 5'd0, 64'hFFFF);
    #1;
    total_cnt++; if (ip_wb_ready !== 1'b1) $display("FAIL x0_ready got %0b want 1", ip_wb_ready); else pass_cnt++;
    next_cycle();
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    total_cnt++; if (rf_wen !== 1'b0 || sb_clr_en !== 1'b0) $display("FAIL x0_wen got %0b/%0b want 0/0", rf_wen, sb_clr_en); else pass_cnt++;
    total_cnt++; if (ip_retire !== 1'b1) $display("FAIL x0_retire got %0b want 1", ip_retire); else pass_cnt++;
    total_cnt++; if (rf_wdata !== 64'h77 || rf_wdst !== 5'd7) $display("FAIL x0_hold got %0d/%0h want 7/77", rf_wdst, rf_wdata); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    drive_ip(1'b1, 1'b1, 5'd12, 64'hC0);
    drive_lsp(1'b1, 1'b1, 5'd13, 64'hD0);
    next_cycle();
    total_cnt++; if (rf_wen !== 1'b1 || starve_cnt !== 3'd1 || lsp_retire !== 1'b1) $display("FAIL rstmid_pre got %0b/%0d/%0b want 1/1/1", rf_wen, starve_cnt, lsp_retire); else pass_cnt++;
    #2 rst_n = 1'b0;
    #1;
    total_cnt++; if (rf_wen !== 1'b0 || sb_clr_en !== 1'b0) $display("FAIL rstmid_wen got %0b/%0b want 0/0", rf_wen, sb_clr_en); else pass_cnt++;
    total_cnt++; if (ip_retire !== 1'b0 || lsp_retire !== 1'b0 || starve_cnt !== 3'd0) $display("FAIL rstmid_state got %0b/%0b/%0d want 0/0/0", ip_retire, lsp_retire, starve_cnt); else pass_cnt++;
    total_cnt++; if (ip_wb_ready !== 1'b0 || lsp_wb_ready !== 1'b0) $display("FAIL rstmid_ready got %0b%0b want 00", ip_wb_ready, lsp_wb_ready); else pass_cnt++;
    drive_lsp(1'b0, 1'b0, 5'd0, 64'h0);
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    next_cycle();
    rst_n = 1'b1;
    drive_ip(1'b1, 1'b1, 5'd14, 64'hE0);
    #1;
    total_cnt++; if (ip_wb_ready !== 1'b1 || rf_wen !== 1'b0) $display("FAIL rstmid_post0 got ready=%0b wen=%0b want 1/0", ip_wb_ready, rf_wen); else pass_cnt++;
    next_cycle();
    drive_ip(1'b0, 1'b0, 5'd0, 64'h0);
    total_cnt++; if (rf_wen !== 1'b1 || rf_wdst !== 5'd14 || rf_wdata !== 64'hE0) $display("FAIL rstmid_post1 got %0b/%0d/%0h want 1/14/e0", rf_wen, rf_wdst, rf_wdata); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_single_ip();
    test_simultaneous();
    test_starvation();
    test_nowb();
    test_x0();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule

// File: doc/wb_sched.md
Name: wb_sched

Overview:
- Writeback scheduler sharing the single register-file write port between the integer pipe (ip) and the load-store pipe (lsp).
- Default priority goes to lsp. An anti-starvation counter forces an ip grant after STARVE_LIMIT consecutive denials.
- Retire-without-writeback and x0 writes are accepted without using the port.
- The granted write is registered: one pipeline stage into the register file, with a matching scoreboard release and per-pipe retire pulses.

Parameters:
STARVE_LIMIT, 4, consecutive cycles ip may be denied while requesting before ip gets forced priority (legal range 1..7)
CNT_W, 3, width of the starvation counter; must hold STARVE_LIMIT

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
ip_wb_dst  in  5  ip destination register
ip_wb_result  in  64  ip result
ip_wb_wb_en  in  1  ip instruction writes a register
ip_wb_valid  in  1  ip writeback request valid
ip_wb_ready  out  1  ip request accepted this cycle (combinational)
lsp_wb_dst  in  5  lsp destination register
lsp_wb_result  in  64  lsp result
lsp_wb_wb_en  in  1  lsp instruction writes a register
lsp_wb_valid  in  1  lsp writeback request valid
lsp_wb_ready  out  1  lsp request accepted (combinational)
rf_wen  out  1  register-file write enable (registered)
rf_wdst  out  5  register-file write index (registered)
rf_wdata  out  64  register-file write data (registered)
sb_clr_en  out  1  scoreboard release, asserted with rf_wen
sb_clr_dst  out  5  scoreboard entry to release, equals rf_wdst
ip_retire  out  1  one-cycle pulse, one ip instruction retired (registered)
lsp_retire  out  1  one-cycle pulse, one lsp instruction retired (registered)
starve_cnt  out  CNT_W  current starvation count (debug)

Behaviour:
Request classification:
- X_wreq = X_wb_valid && X_wb_wb_en && (X_wb_dst != 0).
- X_nowb = X_wb_valid && !X_wreq. This covers wb_en=0 and dst=0. It is always accepted the same cycle (X_wb_ready=1) and never uses the port.

Arbitration, combinational each cycle:
- force_ip = (starve_cnt >= STARVE_LIMIT).
- If both X_wreq: grant lsp unless force_ip, in which case grant ip.
- If only one X_wreq: grant it.
- X_wb_ready = X_nowb || (X_wreq && grant==X). A request that is not ready must be held stable by its source.

Starvation counter:
- Increments (saturating at 2^CNT_W-1) when ip_wreq && grant==lsp.
- Clears to 0 when ip is granted or ip_wreq=0.
- Holds otherwise.

Output stage, registered, latency 1 cycle from accepting handshake:
- On a granted write: rf_wen=1, rf_wdst/rf_wdata = winner's dst/result, sb_clr_en=1, sb_clr_dst=dst.
- With no grant: rf_wen=0 and sb_clr_en=0. rf_wdst, rf_wdata and sb_clr_dst hold their last values.
- X_retire=1 the cycle after any accepted X handshake, whether write or nowb.
- ip_retire and lsp_retire may both be 1 in the same cycle. Example: ip write granted while lsp nowb is retiring.

Boundary conditions:
- Both pipes write the same dst in the same cycle: only the granted one writes that cycle; the loser writes a later cycle. Program order to the same register is guaranteed by the issue scoreboard, not by this block.
- No output stall: the register file always accepts, so the output register updates every cycle.

Reset (async assert, sync deassert externally):
- All outputs 0: rf_wen, rf_wdst, rf_wdata, sb_clr_en, sb_clr_dst, ip_retire, lsp_retire, starve_cnt.
- A write captured in the output register when reset asserts is discarded.
- During reset, X_wb_ready = 0.

Test Plan:
- Single ip write: ip_wb_valid=1, wb_en=1, dst=5, result=0x1234 → ip_wb_ready=1 same cycle; next cycle rf_wen=1, rf_wdst=5, rf_wdata=0x1234, sb_clr_en=1, sb_clr_dst=5, ip_retire=1.
- Simultaneous writes: ip dst=3 and lsp dst=4 both valid → cycle0 lsp ready, ip not ready, starve_cnt→1; cycle1 rf_wdst=4 and ip accepted (lsp now idle); cycle2 rf_wdst=3.
- Starvation, STARVE_LIMIT=4, both pipes writing continuously → lsp granted 4 cycles (starve_cnt 1,2,3,4), 5th cycle ip granted, starve_cnt→0; pattern repeats 4:1.
- Nowb bypass: lsp write dst=7 while ip valid with wb_en=0 → both ready same cycle; next cycle rf_wdst=7, lsp_retire=1, ip_retire=1.
- x0 write: ip wb_en=1, dst=0, result=0xFFFF → ready=1, rf_wen stays 0, sb_clr_en 0, ip_retire=1 next cycle.
- Reset mid-operation: drop rst_n while rf_wen=1 → rf_wen, retire pulses and starve_cnt read 0 immediately (asynchronous); after release, first accepted write appears exactly 1 cycle later.
